// File: rtl/axi_7seg_mux_ctrl.sv
// axi_7seg_mux_ctrl: AXI4-Lite multiplexed 7-segment controller with refresh divider, blanking and byte strobes.
// Define SEG7_PWM_EN to add the BRIGHT register (0x10) and PWM dimming of the active digit.
module axi_7seg_mux_ctrl #(
   parameter int                   NDISP      = 8,
   parameter bit                   MODE_DISP  = 1'b1,
   parameter bit                   MODE_SEG   = 1'b1,
   parameter int                   ADDR_WIDTH = 5,
   parameter int                   DATA_WIDTH = 32,
   parameter int                   DIV_WIDTH  = 20,
   parameter logic [DIV_WIDTH-1:0] DIV_RESET  = 20'hFFFFF
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic [ADDR_WIDTH-1:0] awaddr_i,
   input  logic [2:0]            awprot_i,
   input  logic                  awvalid_i,
   output logic                  awready_o,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [3:0]            wstrb_i,
   input  logic                  wvalid_i,
   output logic                  wready_o,
   output logic [1:0]            bresp_o,
   output logic                  bvalid_o,
   input  logic                  bready_i,
   input  logic [ADDR_WIDTH-1:0] araddr_i,
   input  logic [2:0]            arprot_i,
   input  logic                  arvalid_i,
   output logic                  arready_o,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic [1:0]            rresp_o,
   output logic                  rvalid_o,
   input  logic                  rready_i,
   output logic [NDISP-1:0]      seg_o,
   output logic [6:0]            abcdefg_o,
   output logic                  dp_o
);
   typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_t;
   typedef enum logic {R_IDLE, R_DATA} rstate_t;

   localparam int AW = ADDR_WIDTH - 2;
   localparam logic [AW-1:0] A_DIGITS = AW'(0);
   localparam logic [AW-1:0] A_DP     = AW'(1);
   localparam logic [AW-1:0] A_CTRL   = AW'(2);
   localparam logic [AW-1:0] A_DIV    = AW'(3);
`ifdef SEG7_PWM_EN
   localparam logic [AW-1:0] A_BRIGHT = AW'(4);
   localparam int N_REGS = 5;
`else
   localparam int N_REGS = 4;
`endif
   // Per-register writable bit masks; storage outside them stays zero so reads are RAZ.
   localparam logic [31:0] DIG_M  = 32'hFFFF_FFFF >> (32 - 4 * NDISP);
   localparam logic [31:0] DP_M   = 32'hFFFF_FFFF >> (32 - NDISP);
   localparam logic [31:0] CTRL_M = (DP_M << 8) | 32'd1;
   localparam logic [31:0] DIV_M  = 32'hFFFF_FFFF >> (32 - DIV_WIDTH);
   localparam logic [2:0]  LAST   = 3'(NDISP - 1);
   localparam logic [6:0]  HEX [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                       7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

   function automatic logic [31:0] mrg(input logic [31:0] old, input logic [31:0] nw,
                                       input logic [31:0] m, input logic [31:0] keep);
      return ((old & ~m) | (nw & m)) & keep;
   endfunction

   wstate_t ws_q, ws_d;
   rstate_t rs_q, rs_d;
   logic awready_q, wready_q, arready_q, bvalid_q, rvalid_q;
   logic [1:0] bresp_q, rresp_q;
   logic [31:0] rdata_q, wdata_q;
   logic [3:0] wstrb_q;
   logic [AW-1:0] awaddr_q;
   logic [31:0] digits_q, dpreg_q, ctrl_q, div_q;
   logic [DIV_WIDTH-1:0] cnt_q;
   logic [2:0] idx_q;
   logic [NDISP-1:0] seg_q;
   logic [6:0] abc_q;
   logic dpo_q;
   logic aw_hs, w_hs, ar_hs, have_aw, have_w, do_wr, wr_ok, rd_ok, div_wr, wrap, active;
   logic [AW-1:0] wa, ra;
   logic [31:0] wd, bmask, rd_val;
   logic [3:0] wsb, nib;
   logic [2:0] idx_nx;
   logic unused_bits;

   assign unused_bits = ^{awprot_i, arprot_i, awaddr_i[1:0], araddr_i[1:0]};

   assign aw_hs   = awvalid_i & awready_q;
   assign w_hs    = wvalid_i & wready_q;
   assign ar_hs   = arvalid_i & arready_q;
   assign have_aw = aw_hs | (ws_q == W_HAVE_AW);
   assign have_w  = w_hs | (ws_q == W_HAVE_W);
   assign do_wr   = have_aw & have_w;
   assign wa      = (ws_q == W_HAVE_AW) ? awaddr_q : awaddr_i[ADDR_WIDTH-1:2];
   assign wd      = (ws_q == W_HAVE_W) ? wdata_q : wdata_i;
   assign wsb     = (ws_q == W_HAVE_W) ? wstrb_q : wstrb_i;
   assign bmask   = {{8{wsb[3]}}, {8{wsb[2]}}, {8{wsb[1]}}, {8{wsb[0]}}};
   assign wr_ok   = int'(wa) < N_REGS;
   assign ra      = araddr_i[ADDR_WIDTH-1:2];
   assign rd_ok   = int'(ra) < N_REGS;
   assign div_wr  = do_wr & (wa == A_DIV);

`ifdef SEG7_PWM_EN
   logic [31:0] bright_q;
   logic [3:0] pwm_q;
   always_ff @(posedge clk or negedge nrst)
      if (!nrst) pwm_q <= '0;
      else pwm_q <= pwm_q + 4'd1;
`endif

   always_comb begin
      ws_d = (ws_q == W_RESP) ? (bready_i ? W_IDLE : W_RESP) :
             do_wr ? W_RESP : have_aw ? W_HAVE_AW : have_w ? W_HAVE_W : W_IDLE;
      rs_d = (rs_q == R_DATA) ? (rready_i ? R_IDLE : R_DATA) : (ar_hs ? R_DATA : R_IDLE);
   end

   always_comb begin
      rd_val = '0;
      case (ra)
         A_DIGITS: rd_val = digits_q;
         A_DP:     rd_val = dpreg_q;
         A_CTRL:   rd_val = ctrl_q;
         A_DIV:    rd_val = div_q;
`ifdef SEG7_PWM_EN
         A_BRIGHT: rd_val = bright_q;
`endif
         default:  rd_val = '0;
      endcase
   end

   always_ff @(posedge clk or negedge nrst)
      if (!nrst) begin
         ws_q      <= W_IDLE;
         rs_q      <= R_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         arready_q <= 1'b0;
         bvalid_q  <= 1'b0;
         rvalid_q  <= 1'b0;
         bresp_q   <= '0;
         rresp_q   <= '0;
         rdata_q   <= '0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
      end else begin
         ws_q      <= ws_d;
         rs_q      <= rs_d;
         awready_q <= (ws_d == W_IDLE) || (ws_d == W_HAVE_W);
         wready_q  <= (ws_d == W_IDLE) || (ws_d == W_HAVE_AW);
         bvalid_q  <= ws_d == W_RESP;
         arready_q <= rs_d == R_IDLE;
         rvalid_q  <= rs_d == R_DATA;
         if (aw_hs) awaddr_q <= awaddr_i[ADDR_WIDTH-1:2];
         if (w_hs) begin
            wdata_q <= wdata_i;
            wstrb_q <= wstrb_i;
         end
         if (do_wr) bresp_q <= wr_ok ? 2'b00 : 2'b10;
         // Registers update on this same edge, so rd_val is the pre-write value.
         if (ar_hs) begin
            rdata_q <= rd_ok ? rd_val : '0;
            rresp_q <= rd_ok ? 2'b00 : 2'b10;
         end
      end

   always_ff @(posedge clk or negedge nrst)
      if (!nrst) begin
         digits_q <= '0;
         dpreg_q  <= '0;
         ctrl_q   <= '0;
         div_q    <= 32'(DIV_RESET) & DIV_M;
`ifdef SEG7_PWM_EN
         bright_q <= 32'hF;
`endif
      end else if (do_wr) begin
         if (wa == A_DIGITS) digits_q <= mrg(digits_q, wd, bmask, DIG_M);
         if (wa == A_DP) dpreg_q <= mrg(dpreg_q, wd, bmask, DP_M);
         if (wa == A_CTRL) ctrl_q <= mrg(ctrl_q, wd, bmask, CTRL_M);
         if (wa == A_DIV) div_q <= mrg(div_q, wd, bmask, DIV_M);
`ifdef SEG7_PWM_EN
         if (wa == A_BRIGHT) bright_q <= mrg(bright_q, wd, bmask, 32'hF);
`endif
      end

   assign wrap   = cnt_q == div_q[DIV_WIDTH-1:0];
   assign idx_nx = (idx_q == LAST) ? 3'd0 : idx_q + 3'd1;

   always_ff @(posedge clk or negedge nrst)
      if (!nrst) begin
         cnt_q <= '0;
         idx_q <= '0;
      end else begin
         cnt_q <= (div_wr || wrap) ? '0 : cnt_q + 1'b1;
         idx_q <= div_wr ? 3'd0 : wrap ? idx_nx : idx_q;
      end

   assign nib = digits_q[{idx_q, 2'b00} +: 4];
`ifdef SEG7_PWM_EN
   assign active = ctrl_q[0] & ~ctrl_q[5'(idx_q) + 5'd8] & (pwm_q <= bright_q[3:0]);
`else
   assign active = ctrl_q[0] & ~ctrl_q[5'(idx_q) + 5'd8];
`endif

   // Inactive levels XORed with the active pattern give both polarities.
   always_ff @(posedge clk or negedge nrst)
      if (!nrst) begin
         seg_q <= {NDISP{MODE_DISP}};
         abc_q <= {7{~MODE_SEG}};
         dpo_q <= ~MODE_SEG;
      end else begin
         seg_q <= {NDISP{MODE_DISP}} ^ (NDISP'(active) << idx_q);
         abc_q <= {7{~MODE_SEG}} ^ (active ? HEX[nib] : 7'd0);
         dpo_q <= ~MODE_SEG ^ (active & dpreg_q[5'(idx_q)]);
      end

   assign awready_o = awready_q;
   assign wready_o  = wready_q;
   assign arready_o = arready_q;
   assign bvalid_o  = bvalid_q;
   assign bresp_o   = bresp_q;
   assign rvalid_o  = rvalid_q;
   assign rresp_o   = rresp_q;
   assign rdata_o   = rdata_q;
   assign seg_o     = seg_q;
   assign abcdefg_o = abc_q;
   assign dp_o      = dpo_q;
endmodule

// File: tb/tb_axi_7seg_mux_ctrl.sv
// tb_axi_7seg_mux_ctrl: scoreboard bench for the AXI4-Lite 7-segment controller (default build).
module tb_axi_7seg_mux_ctrl;
   logic clk = 1'b0, nrst = 1'b0;
   logic [4:0] awaddr, araddr;
   logic [2:0] awprot, arprot;
   logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready, dp;
   logic [31:0] wdata, rdata;
   logic [3:0] wstrb;
   logic [1:0] bresp, rresp;
   logic [7:0] seg;
   logic [6:0] abcdefg;
   int total = 0, bad = 0;
   logic [33:0] rq [$];
   logic [1:0] bq [$];
   logic [31:0] m_dig, m_dp, m_ctrl;
   logic [33:0] e;
   localparam logic [6:0] HEXT [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                       7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                       7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                                       7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

   always #5 clk = ~clk;

   axi_7seg_mux_ctrl dut (
      .clk(clk), .nrst(nrst),
      .awaddr_i(awaddr), .awprot_i(awprot), .awvalid_i(awvalid), .awready_o(awready),
      .wdata_i(wdata), .wstrb_i(wstrb), .wvalid_i(wvalid), .wready_o(wready),
      .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
      .araddr_i(araddr), .arprot_i(arprot), .arvalid_i(arvalid), .arready_o(arready),
      .rdata_o(rdata), .rresp_o(rresp), .rvalid_o(rvalid), .rready_i(rready),
      .seg_o(seg), .abcdefg_o(abcdefg), .dp_o(dp)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] er);
      bit ad = 0, wdn = 0;
      int n = 0;
      bq.push_back(er);
      awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
      while (!(ad && wdn) && n < 50) begin
         if (awvalid && awready) ad = 1;
         if (wvalid && wready) wdn = 1;
         @(negedge clk);
         if (ad) awvalid = 0;
         if (wdn) wvalid = 0;
         n++;
      end
      chk("wr_hs", {30'd0, ad, wdn}, 32'd3);
      n = 0;
      while (!bvalid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("bvalid", bvalid, 1);
      chk("bresp", bresp, bq.pop_front());
      @(negedge clk);
      bready = 0;
      chk("bvalid_clr", bvalid, 0);
   endtask

   task automatic rd(input logic [4:0] a, input logic [31:0] ed, input logic [1:0] er);
      int n = 0;
      rq.push_back({er, ed});
      araddr = a; arvalid = 1; rready = 1;
      while (!arready && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      arvalid = 0;
      n = 0;
      while (!rvalid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("rvalid", rvalid, 1);
      e = rq.pop_front();
      chk("rdata", rdata, e[31:0]);
      chk("rresp", rresp, e[33:32]);
      @(negedge clk);
   endtask

   // Called right after a DIV write returns: cycle j shows digit (j/(div+1)) mod 8.
   task automatic disp(input int cycles, input int div);
      for (int j = 0; j < cycles; j++) begin
         int i;
         logic act;
         logic [7:0] es;
         logic [6:0] ea;
         i = (j / (div + 1)) % 8;
         act = m_ctrl[0] && !m_ctrl[8 + i];
         es = act ? ~(8'd1 << i) : 8'hFF;
         ea = act ? HEXT[m_dig[4*i +: 4]] : 7'd0;
         chk("seg", {24'd0, seg}, {24'd0, es});
         chk("abcdefg", {25'd0, abcdefg}, {25'd0, ea});
         chk("dp", {31'd0, dp}, {31'd0, act & m_dp[i]});
         @(negedge clk);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      awaddr = 0; araddr = 0; awprot = 0; arprot = 0; awvalid = 0; wvalid = 0; bready = 0;
      arvalid = 0; rready = 0; wdata = 0; wstrb = 0;
      m_dig = 0; m_dp = 0; m_ctrl = 0;
      repeat (3) @(negedge clk);
      chk("rst_seg", {24'd0, seg}, 32'hFF);
      chk("rst_abc", {25'd0, abcdefg}, 0);
      chk("rst_dp", {31'd0, dp}, 0);
      chk("rst_rdy", {29'd0, awready, wready, arready}, 0);
      chk("rst_valid", {30'd0, bvalid, rvalid}, 0);
      chk("rst_rdata", rdata, 0);
      nrst = 1;
      @(negedge clk);
      chk("idle_rdy", {29'd0, awready, wready, arready}, 32'd7);
      rd(5'h0C, 32'h000F_FFFF, 2'b00);
      m_dig = 32'h7654_3210;
      wr(5'h00, m_dig, 4'hF, 2'b00);
      m_ctrl = 32'h1;
      wr(5'h08, m_ctrl, 4'hF, 2'b00);
      wr(5'h0C, 32'd3, 4'hF, 2'b00);
      disp(40, 3);
      m_dp = 32'h2;
      wr(5'h04, m_dp, 4'hF, 2'b00);
      wr(5'h0C, 32'd0, 4'hF, 2'b00);
      disp(20, 0);
      m_ctrl = 32'h0401;
      wr(5'h08, m_ctrl, 4'hF, 2'b00);
      wr(5'h0C, 32'd3, 4'hF, 2'b00);
      disp(40, 3);
      m_ctrl = 32'h0;
      wr(5'h08, m_ctrl, 4'hF, 2'b00);
      wr(5'h0C, 32'd1, 4'hF, 2'b00);
      disp(8, 1);
      wr(5'h00, 32'h0000_AB00, 4'b0010, 2'b00);
      m_dig = 32'h7654_AB10;
      rd(5'h00, m_dig, 2'b00);
      wr(5'h04, 32'hFF, 4'b0000, 2'b00);
      rd(5'h04, m_dp, 2'b00);
      wr(5'h08, 32'hFFFF_FFFF, 4'hF, 2'b00);
      rd(5'h08, 32'h0000_FF01, 2'b00);
      rd(5'h0E, 32'd1, 2'b00);
      rd(5'h14, 32'd0, 2'b10);
      wr(5'h18, 32'hDEAD_BEEF, 4'hF, 2'b10);
      rd(5'h00, m_dig, 2'b00);
`ifdef SEG7_PWM_EN
      rd(5'h10, 32'hF, 2'b00);
`else
      rd(5'h10, 32'd0, 2'b10);
`endif
      // W three cycles ahead of AW, response held off for five cycles.
      bq.push_back(2'b00);
      wdata = 32'h1357_2468; wstrb = 4'hF; wvalid = 1; bready = 0;
      @(negedge clk);
      wvalid = 0;
      chk("havew_wready", wready, 0);
      chk("havew_awready", awready, 1);
      repeat (2) @(negedge clk);
      awaddr = 5'h00; awvalid = 1;
      @(negedge clk);
      awvalid = 0;
      for (int k = 0; k < 5; k++) begin
         chk("resp_hold", bvalid, 1);
         chk("resp_awready", awready, 0);
         @(negedge clk);
      end
      chk("late_bresp", bresp, bq.pop_front());
      bready = 1;
      @(negedge clk);
      bready = 0;
      chk("late_bclr", bvalid, 0);
      chk("late_idle", {30'd0, awready, wready}, 32'd3);
      m_dig = 32'h1357_2468;
      rd(5'h00, m_dig, 2'b00);
      // Simultaneous read and write of DIGITS returns the old value.
      rq.push_back({2'b00, m_dig});
      bq.push_back(2'b00);
      awaddr = 5'h00; wdata = 32'hCAFE_F00D; wstrb = 4'hF; araddr = 5'h00;
      awvalid = 1; wvalid = 1; arvalid = 1; bready = 1; rready = 1;
      @(negedge clk);
      awvalid = 0; wvalid = 0; arvalid = 0;
      e = rq.pop_front();
      chk("rw_rvalid", rvalid, 1);
      chk("rw_rdata", rdata, e[31:0]);
      chk("rw_bvalid", bvalid, 1);
      chk("rw_bresp", bresp, bq.pop_front());
      @(negedge clk);
      bready = 0;
      rd(5'h00, 32'hCAFE_F00D, 2'b00);
      // Reset while a response is pending.
      m_ctrl = 32'h1;
      wr(5'h08, m_ctrl, 4'hF, 2'b00);
      awaddr = 5'h0C; wdata = 32'd5; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
      @(negedge clk);
      awvalid = 0; wvalid = 0;
      chk("pend_bvalid", bvalid, 1);
      nrst = 0;
      #1;
      chk("mid_bvalid", bvalid, 0);
      chk("mid_rdy", {29'd0, awready, wready, arready}, 0);
      chk("mid_seg", {24'd0, seg}, 32'hFF);
      chk("mid_abc", {25'd0, abcdefg}, 0);
      @(negedge clk);
      nrst = 1;
      @(negedge clk);
      rd(5'h0C, 32'h000F_FFFF, 2'b00);
      rd(5'h00, 32'd0, 2'b00);
      rd(5'h08, 32'd0, 2'b00);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
